// File: rtl/waypoint_error_gen.sv
// Waypoint error generator: holds a table of target poses and emits registered
// sign-magnitude (target - pose) errors, advancing once each waypoint has settled.
module waypoint_error_gen #(
  parameter int                 N_WIDTH    = 17,
  parameter int                 N_WP       = 8,
  parameter int                 AW         = 3,
  parameter logic [N_WIDTH-1:0] TOL_XY     = 17'h0001A,
  parameter logic [N_WIDTH-1:0] TOL_Z      = 17'h00A00,
  parameter int                 SETTLE_UPD = 4
) (
  input  logic               WAYPOINT_ERROR_CLOCK_50,
  input  logic               WAYPOINT_ERROR_RESET_InHigh,
  input  logic               WAYPOINT_ERROR_START_In,
  input  logic               WAYPOINT_ERROR_WP_WE_In,
  input  logic [AW-1:0]      WAYPOINT_ERROR_WP_ADDR_InBus,
  input  logic [N_WIDTH-1:0] WAYPOINT_ERROR_WP_X_InBus,
  input  logic [N_WIDTH-1:0] WAYPOINT_ERROR_WP_Y_InBus,
  input  logic [N_WIDTH-1:0] WAYPOINT_ERROR_WP_Z_InBus,
  input  logic [AW:0]        WAYPOINT_ERROR_WP_COUNT_InBus,
  input  logic               WAYPOINT_ERROR_POSE_VALID_In,
  input  logic [N_WIDTH-1:0] WAYPOINT_ERROR_POSE_X_InBus,
  input  logic [N_WIDTH-1:0] WAYPOINT_ERROR_POSE_Y_InBus,
  input  logic [N_WIDTH-1:0] WAYPOINT_ERROR_POSE_Z_InBus,
  output logic [N_WIDTH-1:0] WAYPOINT_ERROR_X_OutBus,
  output logic [N_WIDTH-1:0] WAYPOINT_ERROR_Y_OutBus,
  output logic [N_WIDTH-1:0] WAYPOINT_ERROR_Z_OutBus,
  output logic               WAYPOINT_ERROR_VALID_Out,
  output logic [AW-1:0]      WAYPOINT_ERROR_INDEX_OutBus,
  output logic               WAYPOINT_ERROR_BUSY_Out,
  output logic               WAYPOINT_ERROR_DONE_Out
);

  localparam int          MW       = N_WIDTH - 1;
  localparam logic [AW:0] L_N_WP   = (AW+1)'(N_WP);
  localparam logic [3:0]  L_SETTLE = 4'(SETTLE_UPD);

  typedef enum logic [1:0] {IDLE, TRACK, SETTLE, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_index, w_index_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [AW:0]        r_count, w_count_nxt;
  logic [N_WIDTH-1:0] r_ex, r_ey, r_ez, w_ex_nxt, w_ey_nxt, w_ez_nxt;
  logic               r_valid, w_valid_nxt;

  logic [N_WIDTH-1:0] r_wp_x [N_WP];
  logic [N_WIDTH-1:0] r_wp_y [N_WP];
  logic [N_WIDTH-1:0] r_wp_z [N_WP];

  logic [N_WIDTH-1:0] w_ex, w_ey, w_ez;
  logic               w_in_tol, w_advance, w_is_last;
  logic [AW:0]        w_count_clamped;

  // a - b in sign-magnitude: negate b's sign, then add with saturation.
  function automatic logic [N_WIDTH-1:0] sm_sub(input logic [N_WIDTH-1:0] a,
                                                input logic [N_WIDTH-1:0] b);
    logic          sa, sb, sgn;
    logic [MW-1:0] ma, mb, mag;
    logic [MW:0]   sum;
    sa  = a[MW];
    sb  = ~b[MW];
    ma  = a[MW-1:0];
    mb  = b[MW-1:0];
    sum = '0;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
      mag = sum[MW] ? '1 : sum[MW-1:0];
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  assign w_ex = sm_sub(r_wp_x[r_index], WAYPOINT_ERROR_POSE_X_InBus);
  assign w_ey = sm_sub(r_wp_y[r_index], WAYPOINT_ERROR_POSE_Y_InBus);
  assign w_ez = sm_sub(r_wp_z[r_index], WAYPOINT_ERROR_POSE_Z_InBus);

  assign w_in_tol = (w_ex[MW-1:0] <= TOL_XY[MW-1:0]) &&
                    (w_ey[MW-1:0] <= TOL_XY[MW-1:0]) &&
                    (w_ez[MW-1:0] <= TOL_Z[MW-1:0]);

  assign w_count_clamped = (WAYPOINT_ERROR_WP_COUNT_InBus > L_N_WP) ? L_N_WP
                                                                    : WAYPOINT_ERROR_WP_COUNT_InBus;
  assign w_is_last = (({1'b0, r_index} + (AW+1)'(1)) == r_count);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_cnt_nxt   = r_cnt;
    w_count_nxt = r_count;
    w_ex_nxt    = r_ex;
    w_ey_nxt    = r_ey;
    w_ez_nxt    = r_ez;
    w_valid_nxt = 1'b0;
    w_advance   = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (WAYPOINT_ERROR_START_In) begin
          w_count_nxt = w_count_clamped;
          if (w_count_clamped == '0) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b1;
            w_ex_nxt    = '0;
            w_ey_nxt    = '0;
            w_ez_nxt    = '0;
          end else begin
            w_state_nxt = TRACK;
            w_index_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      TRACK, SETTLE: begin
        if (WAYPOINT_ERROR_POSE_VALID_In) begin
          w_ex_nxt    = w_ex;
          w_ey_nxt    = w_ey;
          w_ez_nxt    = w_ez;
          w_valid_nxt = 1'b1;
          if (!w_in_tol) begin
            w_state_nxt = TRACK;
            w_cnt_nxt   = '0;
          end else if (r_cnt + 4'd1 >= L_SETTLE) begin
            w_advance = 1'b1;
          end else begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Errors registered on the advance edge still refer to the old waypoint.
    if (w_advance) begin
      w_cnt_nxt = '0;
      if (w_is_last) begin
        w_state_nxt = DONE;
        w_ex_nxt    = '0;
        w_ey_nxt    = '0;
        w_ez_nxt    = '0;
      end else begin
        w_state_nxt = TRACK;
        w_index_nxt = r_index + AW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge WAYPOINT_ERROR_CLOCK_50) begin
    if (WAYPOINT_ERROR_RESET_InHigh) begin
      r_state <= IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_count <= '0;
      r_ex    <= '0;
      r_ey    <= '0;
      r_ez    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_cnt   <= w_cnt_nxt;
      r_count <= w_count_nxt;
      r_ex    <= w_ex_nxt;
      r_ey    <= w_ey_nxt;
      r_ez    <= w_ez_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // NOTE: the waypoint table is deliberately not reset; it survives a control reset.
  always_ff @(posedge WAYPOINT_ERROR_CLOCK_50) begin
    if (WAYPOINT_ERROR_WP_WE_In && (r_state == IDLE || r_state == DONE)) begin
      r_wp_x[WAYPOINT_ERROR_WP_ADDR_InBus] <= WAYPOINT_ERROR_WP_X_InBus;
      r_wp_y[WAYPOINT_ERROR_WP_ADDR_InBus] <= WAYPOINT_ERROR_WP_Y_InBus;
      r_wp_z[WAYPOINT_ERROR_WP_ADDR_InBus] <= WAYPOINT_ERROR_WP_Z_InBus;
    end
  end

  assign WAYPOINT_ERROR_X_OutBus     = r_ex;
  assign WAYPOINT_ERROR_Y_OutBus     = r_ey;
  assign WAYPOINT_ERROR_Z_OutBus     = r_ez;
  assign WAYPOINT_ERROR_VALID_Out    = r_valid;
  assign WAYPOINT_ERROR_INDEX_OutBus = r_index;
  assign WAYPOINT_ERROR_BUSY_Out     = (r_state == TRACK) || (r_state == SETTLE);
  assign WAYPOINT_ERROR_DONE_Out     = (r_state == DONE);

endmodule

// File: tb/tb_waypoint_error_gen.sv
// Scoreboard bench for waypoint_error_gen: directed poses push expected errors,
// a negedge monitor pops and compares on every VALID pulse.
module tb_waypoint_error_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        we;
  logic [2:0]  addr;
  logic [16:0] wp_x, wp_y, wp_z;
  logic [3:0]  count;
  logic        pose_valid;
  logic [16:0] pose_x, pose_y, pose_z;
  logic [16:0] ex, ey, ez;
  logic        valid;
  logic [2:0]  index;
  logic        busy, done;

  typedef struct packed {
    logic [16:0] x;
    logic [16:0] y;
    logic [16:0] z;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  waypoint_error_gen dut (
    .WAYPOINT_ERROR_CLOCK_50      (clk),
    .WAYPOINT_ERROR_RESET_InHigh  (rst),
    .WAYPOINT_ERROR_START_In      (start),
    .WAYPOINT_ERROR_WP_WE_In      (we),
    .WAYPOINT_ERROR_WP_ADDR_InBus (addr),
    .WAYPOINT_ERROR_WP_X_InBus    (wp_x),
    .WAYPOINT_ERROR_WP_Y_InBus    (wp_y),
    .WAYPOINT_ERROR_WP_Z_InBus    (wp_z),
    .WAYPOINT_ERROR_WP_COUNT_InBus(count),
    .WAYPOINT_ERROR_POSE_VALID_In (pose_valid),
    .WAYPOINT_ERROR_POSE_X_InBus  (pose_x),
    .WAYPOINT_ERROR_POSE_Y_InBus  (pose_y),
    .WAYPOINT_ERROR_POSE_Z_InBus  (pose_z),
    .WAYPOINT_ERROR_X_OutBus      (ex),
    .WAYPOINT_ERROR_Y_OutBus      (ey),
    .WAYPOINT_ERROR_Z_OutBus      (ez),
    .WAYPOINT_ERROR_VALID_Out     (valid),
    .WAYPOINT_ERROR_INDEX_OutBus  (index),
    .WAYPOINT_ERROR_BUSY_Out      (busy),
    .WAYPOINT_ERROR_DONE_Out      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [16:0] x, input logic [16:0] y,
                    input logic [16:0] z);
    we = 1'b1; addr = a; wp_x = x; wp_y = y; wp_z = z;
    tick();
    we = 1'b0;
  endtask

  task automatic pose(input logic [16:0] px, input logic [16:0] py, input logic [16:0] pz,
                      input logic [16:0] qx, input logic [16:0] qy, input logic [16:0] qz);
    pose_x = px; pose_y = py; pose_z = pz;
    pose_valid = 1'b1;
    sb_q.push_back('{x: qx, y: qy, z: qz});
    tick();
    pose_valid = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] c);
    count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: every VALID pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("err_x", {15'd0, ex}, {15'd0, e.x});
          check("err_y", {15'd0, ey}, {15'd0, e.y});
          check("err_z", {15'd0, ez}, {15'd0, e.z});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0;
    wp_x = '0; wp_y = '0; wp_z = '0; count = '0;
    pose_valid = 1'b0; pose_x = '0; pose_y = '0; pose_z = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_x", {15'd0, ex}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_index", {29'd0, index}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // START with count 0 goes straight to DONE with one zero-error VALID
    sb_q.push_back('{x: 17'h0, y: 17'h0, z: 17'h0});
    do_start(4'd0);
    check("cnt0_done", {31'd0, done}, 32'd1);
    check("cnt0_busy", {31'd0, busy}, 32'd0);

    wr(3'd0, 17'h00100, 17'h00000, 17'h00000);
    wr(3'd1, 17'h10080, 17'h0FFFF, 17'h00000);
    do_start(4'd2);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_index", {29'd0, index}, 32'd0);

    // Basic arithmetic and exact one-cycle latency
    pose(17'h00040, 17'h00000, 17'h00000, 17'h000C0, 17'h00000, 17'h00000);
    check("lat_valid_hi", {31'd0, valid}, 32'd1);
    tick();
    check("lat_valid_lo", {31'd0, valid}, 32'd0);
    check("hold_x", {15'd0, ex}, 32'h000C0);

    // Write during TRACK must be ignored
    wr(3'd0, 17'h01234, 17'h00555, 17'h00777);

    // Settling on waypoint 0: 3 in, 1 out, 4 in
    pose(17'h00100, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    pose(17'h000F0, 17'h00000, 17'h00000, 17'h00010, 17'h00000, 17'h00000);
    pose(17'h00100, 17'h00000, 17'h10500, 17'h00000, 17'h00000, 17'h00500);
    do_start(4'd0);
    check("start_in_settle_busy", {31'd0, busy}, 32'd1);
    check("start_in_settle_done", {31'd0, done}, 32'd0);
    pose(17'h00100, 17'h1001B, 17'h00000, 17'h00000, 17'h0001B, 17'h00000);
    pose(17'h00100, 17'h1001A, 17'h00000, 17'h00000, 17'h0001A, 17'h00000);
    pose(17'h00100, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    pose(17'h0011A, 17'h00000, 17'h00000, 17'h1001A, 17'h00000, 17'h00000);
    check("idx_before_8th", {29'd0, index}, 32'd0);
    pose(17'h00100, 17'h00000, 17'h00A00, 17'h00000, 17'h00000, 17'h10A00);
    check("idx_after_8th", {29'd0, index}, 32'd1);
    check("busy_after_8th", {31'd0, busy}, 32'd1);

    // Waypoint 1: sign handling, saturation, equal operands, forced zero on DONE
    pose(17'h00080, 17'h10100, 17'h00300, 17'h10100, 17'h0FFFF, 17'h10300);
    pose(17'h10080, 17'h0FFFF, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    pose(17'h10080, 17'h0FFFF, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    pose(17'h10080, 17'h0FFFF, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    pose(17'h10090, 17'h0FFFF, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    check("fin_done", {31'd0, done}, 32'd1);
    check("fin_busy", {31'd0, busy}, 32'd0);
    check("fin_index", {29'd0, index}, 32'd1);
    check("fin_x", {15'd0, ex}, 32'd0);
    check("fin_y", {15'd0, ey}, 32'd0);
    check("fin_z", {15'd0, ez}, 32'd0);

    // Reset mid-SETTLE, then restart with POSE_VALID on the START cycle
    do_start(4'd2);
    pose(17'h000F0, 17'h00000, 17'h00000, 17'h00010, 17'h00000, 17'h00000);
    check("pre_rst_x", {15'd0, ex}, 32'h00010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_x", {15'd0, ex}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_index", {29'd0, index}, 32'd0);
    count = 4'd1; start = 1'b1; pose_valid = 1'b1; pose_x = 17'h00040;
    tick();
    start = 1'b0; pose_valid = 1'b0;
    check("restart_valid", {31'd0, valid}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_index", {29'd0, index}, 32'd0);
    for (int i = 0; i < 4; i++)
      pose(17'h00100, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000);
    check("restart_done", {31'd0, done}, 32'd1);

    tick(); tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
